// File: rtl/stream_merge_pkg.sv
// Shared definitions for the round-robin stream merger: FSM encoding and the
// rotating-priority winner search used by rr_priority_pick.
package stream_merge_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int RR_MAX_PORTS = 16;

    // Returns the first requesting index found scanning ptr, ptr+1, ... mod n.
    // Returns 0 when nothing is requesting; callers qualify with |req.
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input logic [4:0]  n);
        logic [3:0] idx;
        logic       found;
        logic [4:0] k;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_PORTS; i++) begin
            // ptr < n and i < n, so one conditional subtract is a full modulo
            k = {1'b0, ptr} + 5'(i);
            if (k >= n) begin
                k = k - n;
            end
            if ((5'(i) < n) && !found && req[k[3:0]]) begin
                idx   = k[3:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: picks the first set bit of req
// starting at ptr and wrapping modulo NUM_PORTS.
module rr_priority_pick
    import stream_merge_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ID_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_WIDTH-1:0]  ptr,
    output logic                 valid,
    output logic [ID_WIDTH-1:0]  idx
);

    logic [3:0] pick;

    // Widen to the package search width and narrow the result back.
    always_comb begin
        pick  = rr_pick(16'(req), 4'(ptr), 5'(NUM_PORTS));
        valid = |req;
        idx   = ID_WIDTH'(pick);
    end

endmodule

// File: rtl/stream_rr_merge.sv
// N-to-1 round-robin merger of FWFT FIFO read ports into one FIFO write port.
// A grant is held for up to MAX_BURST words; each new grant costs one bubble.
// Optional build macro STREAM_RR_MERGE_STALL_CNT_EN adds a saturating 32-bit
// count of cycles in which a held output word is blocked by out_full_n=0.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | searching for the next non-empty port from rr_ptr; no pops
//   GRANT | popping the granted port while the output stage is free
module stream_rr_merge
    import stream_merge_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            in_empty_n,
    output logic [NUM_PORTS-1:0]            in_read,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dout,
    input  logic                            out_full_n,
    output logic                            out_write,
    output logic [DATA_WIDTH-1:0]           out_din,
    output logic [ID_WIDTH-1:0]             out_id
`ifdef STREAM_RR_MERGE_STALL_CNT_EN
    ,
    output logic [31:0]                     stall_cnt
`endif
);

    localparam int                     CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0]    LAST_ID  = ID_WIDTH'(NUM_PORTS - 1);

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic                    out_write_q, out_write_d;
    logic [DATA_WIDTH-1:0]   out_din_q, out_din_d;
    logic [ID_WIDTH-1:0]     out_id_q, out_id_d;

    logic                    stage_free;
    logic                    pop;
    logic                    release_grant;
    logic                    pick_valid;
    logic [ID_WIDTH-1:0]     pick_idx;
    logic [DATA_WIDTH-1:0]   grant_dout;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_pick (
        .req   (in_empty_n),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Pop decode: only the granted port, only into a free output stage, never during reset.
    always_comb begin
        stage_free       = ~out_write_q | out_full_n;
        grant_dout       = in_dout[grant_q*DATA_WIDTH +: DATA_WIDTH];
        pop              = (state_q == GRANT) & in_empty_n[grant_q] & stage_free & ~reset;
        in_read          = '0;
        in_read[grant_q] = pop;
    end

    // Next-state, grant/burst bookkeeping and output-stage load.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        out_write_d   = out_write_q;
        out_din_d     = out_din_q;
        out_id_d      = out_id_q;
        release_grant = 1'b0;

        // A held word leaves whenever the stage is free; a pop below refills it.
        if (stage_free) begin
            out_write_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (pop) begin
                    out_write_d = 1'b1;
                    out_din_d   = grant_dout;
                    out_id_d    = grant_q;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == LAST_CNT) begin
                        release_grant = 1'b1;
                    end
                end else if (stage_free && !in_empty_n[grant_q]) begin
                    // Backpressure alone keeps the grant; only a dry port releases early.
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any held output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            out_write_q <= 1'b0;
            out_din_q   <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            out_write_q <= out_write_d;
            out_din_q   <= out_din_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_write = out_write_q;
    assign out_din   = out_din_q;
    assign out_id    = out_id_q;

`ifdef STREAM_RR_MERGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count blocked-output cycles, saturating at all ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_write_q && !out_full_n && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stream_rr_merge.sv
// Directed bench for stream_rr_merge: dut0 uses MAX_BURST=4, dut1 MAX_BURST=1.
// Each DUT reads from a small FIFO model whose word k,i is word(k,i).
module tb_stream_rr_merge;
    import stream_merge_pkg::*;

    localparam int NP = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    en0, en1, rd0, rd1;
    logic [NP*DW-1:0] dout0, dout1;
    logic             full_n0 = 1'b1;
    logic             full_n1 = 1'b1;
    logic             ow0, ow1;
    logic [DW-1:0]    od0, od1;
    logic [1:0]       oi0, oi1;
`ifdef STREAM_RR_MERGE_STALL_CNT_EN
    logic [31:0]      stall0, stall1;
`endif

    int avail0[NP];
    int avail1[NP];
    int rp0[NP];
    int rp1[NP];
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] ld0[64];
    logic [DW-1:0] ld1[64];
    logic [1:0]    li0[64];
    logic [1:0]    li1[64];
    int            lc0[64];
    int            lc1[64];
    int            ln0, ln1;
    int            first_rd0, last_wr0;

    stream_rr_merge #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(4)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (en0),
        .in_read    (rd0),
        .in_dout    (dout0),
        .out_full_n (full_n0),
        .out_write  (ow0),
        .out_din    (od0),
        .out_id     (oi0)
`ifdef STREAM_RR_MERGE_STALL_CNT_EN
        ,
        .stall_cnt  (stall0)
`endif
    );

    stream_rr_merge #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (en1),
        .in_read    (rd1),
        .in_dout    (dout1),
        .out_full_n (full_n1),
        .out_write  (ow1),
        .out_din    (od1),
        .out_id     (oi1)
`ifdef STREAM_RR_MERGE_STALL_CNT_EN
        ,
        .stall_cnt  (stall1)
`endif
    );

    function automatic logic [31:0] word(input int p, input int i);
        return 32'(((p + 1) << 28) + i);
    endfunction

    // FIFO model heads
    always_comb begin
        en0   = '0;
        en1   = '0;
        dout0 = '0;
        dout1 = '0;
        for (int k = 0; k < NP; k++) begin
            en0[k]             = rp0[k] < avail0[k];
            en1[k]             = rp1[k] < avail1[k];
            dout0[k*DW +: DW]  = word(k, rp0[k]);
            dout1[k*DW +: DW]  = word(k, rp1[k]);
        end
    end

    // FIFO model pops and cycle counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NP; k++) begin
            if (reset) begin
                rp0[k] <= 0;
                rp1[k] <= 0;
            end else begin
                if (rd0[k]) rp0[k] <= rp0[k] + 1;
                if (rd1[k]) rp1[k] <= rp1[k] + 1;
            end
        end
    end

    // Transfer log, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            ln0       <= 0;
            ln1       <= 0;
            first_rd0 <= -1;
            last_wr0  <= -1;
        end else begin
            if (ow0 && full_n0 && ln0 < 64) begin
                ld0[ln0] <= od0;
                li0[ln0] <= oi0;
                lc0[ln0] <= cyc;
                ln0      <= ln0 + 1;
            end
            if (ow1 && full_n1 && ln1 < 64) begin
                ld1[ln1] <= od1;
                li1[ln1] <= oi1;
                lc1[ln1] <= cyc;
                ln1      <= ln1 + 1;
            end
            if (rd0 != '0 && first_rd0 < 0) first_rd0 <= cyc;
            if (ow0) last_wr0 <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_on();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        full_n0 = 1'b1;
        full_n1 = 1'b1;
        for (int k = 0; k < NP; k++) begin
            avail0[k] = 0;
            avail1[k] = 0;
        end
    endtask

    task automatic reset_off();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int t1_gap[6] = '{0, 1, 2, 3, 5, 6};
        int t3_id[7]  = '{1, 1, 3, 3, 3, 3, 3};
        int t3_ix[7]  = '{0, 1, 0, 1, 2, 3, 4};
        int t6_id[4]  = '{0, 3, 0, 3};
        int t6_ix[4]  = '{0, 0, 1, 1};

        for (int k = 0; k < NP; k++) begin
            avail0[k] = 0;
            avail1[k] = 0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_write", 64'(ow0), 64'd0);
        check("rst_out_din", 64'(od0), 64'd0);
        check("rst_out_id", 64'(oi0), 64'd0);
        check("rst_in_read", 64'(rd0), 64'd0);
        check("rst_idle", 64'(dut0.state_q == IDLE), 64'd1);
        check("rst_rr_ptr", 64'(dut0.rr_ptr_q), 64'd0);
        check("rst_burst_cnt", 64'(dut0.burst_cnt_q), 64'd0);
`ifdef STREAM_RR_MERGE_STALL_CNT_EN
        check("rst_stall_cnt", 64'(stall0), 64'd0);
`endif

        // Single active port 2 with six words
        reset_on();
        avail0[2] = 6;
        reset_off();
        repeat (12) @(posedge clk);
        #2;
        check("t1_count", 64'(ln0), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check("t1_data", 64'(ld0[i]), 64'(word(2, i)));
            check("t1_id", 64'(li0[i]), 64'd2);
            check("t1_gap", 64'(lc0[i] - lc0[0]), 64'(t1_gap[i]));
        end
        check("t1_span", 64'(last_wr0 - first_rd0), 64'd7);

        // All ports busy: 4-word bursts with one bubble between them
        reset_on();
        for (int k = 0; k < NP; k++) avail0[k] = 1000;
        reset_off();
        repeat (28) @(posedge clk);
        #2;
        check("t2_count_ge20", 64'(ln0 >= 20), 64'd1);
        for (int i = 0; i < 20; i++) begin
            check("t2_id", 64'(li0[i]), 64'((i / 4) % 4));
            check("t2_data", 64'(ld0[i]), 64'(word((i / 4) % 4, (i / 16) * 4 + i % 4)));
            if (i > 0) begin
                check("t2_gap", 64'(lc0[i] - lc0[i-1]), (i % 4 == 0) ? 64'd2 : 64'd1);
            end
        end

        // Port 1 runs dry after 2 words, port 3 pending
        reset_on();
        avail0[1] = 2;
        avail0[3] = 5;
        reset_off();
        repeat (5) @(negedge clk);
        check("t3_idle_after_release", 64'(dut0.state_q == IDLE), 64'd1);
        check("t3_rr_ptr", 64'(dut0.rr_ptr_q), 64'd2);
        repeat (8) @(posedge clk);
        #2;
        check("t3_count", 64'(ln0), 64'd7);
        for (int i = 0; i < 7; i++) begin
            check("t3_id", 64'(li0[i]), 64'(t3_id[i]));
            check("t3_data", 64'(ld0[i]), 64'(word(t3_id[i], t3_ix[i])));
        end

        // Backpressure for 5 cycles while holding a word
        reset_on();
        avail0[0] = 1000;
        reset_off();
        repeat (2) @(posedge clk);
        #1;
        full_n0 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("t4_hold_write", 64'(ow0), 64'd1);
            check("t4_hold_din", 64'(od0), 64'(word(0, 0)));
            check("t4_hold_id", 64'(oi0), 64'd0);
            check("t4_no_read", 64'(rd0), 64'd0);
            check("t4_grant_held", 64'(dut0.state_q == GRANT && dut0.grant_q == 2'd0), 64'd1);
        end
        @(posedge clk);
        #1;
        full_n0 = 1'b1;
        @(negedge clk);
`ifdef STREAM_RR_MERGE_STALL_CNT_EN
        check("t4_stall_cnt", 64'(stall0), 64'd5);
`endif
        repeat (4) @(posedge clk);
        #2;
        check("t4_first_word", 64'(ld0[0]), 64'(word(0, 0)));
        check("t4_second_word", 64'(ld0[1]), 64'(word(0, 1)));
        check("t4_third_word", 64'(ld0[2]), 64'(word(0, 2)));

        // Reset mid-burst of port 2 while a word is held
        reset_on();
        avail0[1] = 1000;
        avail0[2] = 1000;
        reset_off();
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("t5_pre_write", 64'(ow0), 64'd1);
        check("t5_pre_id", 64'(oi0), 64'd2);
        check("t5_no_read_in_reset", 64'(rd0), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_write_cleared", 64'(ow0), 64'd0);
        check("t5_din_cleared", 64'(od0), 64'd0);
        check("t5_read_zero", 64'(rd0), 64'd0);
        check("t5_idle", 64'(dut0.state_q == IDLE), 64'd1);
        @(negedge clk);
        check("t5_regrant_lowest", 64'(rd0), 64'b0010);

        // MAX_BURST=1 with ports 0 and 3
        reset_on();
        avail1[0] = 1000;
        avail1[3] = 1000;
        reset_off();
        repeat (10) @(posedge clk);
        #2;
        check("t6_count_ge4", 64'(ln1 >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("t6_id", 64'(li1[i]), 64'(t6_id[i]));
            check("t6_data", 64'(ld1[i]), 64'(word(t6_id[i], t6_ix[i])));
            check("t6_gap", 64'(lc1[i] - lc1[0]), 64'(2 * i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
